data_checker: RTL and testbench

- Downstream consumer of the 512-bit packet-generator AXI stream.
- Accepts beats (optionally with pseudo-random backpressure) and checks every beat against the known pattern: marker word, per-word tag, running 8-bit beat counter, 16-bit packet number.
- Enforces the configured packet length and reports sticky error status plus packet, beat and error counters for software readout.

---
 rtl/axis_rx_if.sv | 24 ++
 rtl/data_checker.sv | 164 ++++++++++++++++
 tb/tb_data_checker.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/axis_rx_if.sv
// 512-bit AXI stream bundle between the packet generator and data_checker.
interface axis_rx_if;
    logic [511:0] tdata;
    logic [63:0]  tkeep;
    logic         tvalid;
    logic         tlast;
    logic         tready;

    modport master (
        output tdata,
        output tkeep,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/data_checker.sv
// Consumes the generator AXI stream, checks every beat against the known
// pattern and keeps sticky error status plus packet/beat/error counters.
module data_checker #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          ERR_W     = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic [7:0]       packet_length,
    input  logic             throttle_en,
    axis_rx_if.slave         axis_rx,
    output logic [63:0]      packets_rcvd,
    output logic [63:0]      beats_rcvd,
    output logic [ERR_W-1:0] error_count,
    output logic [3:0]       error_flags,
    output logic [15:0]      first_err_packet,
    output logic [3:0]       first_err_flags,
    output logic             synced
);

    typedef enum logic {SYNC, CHECK} state_t;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] lfsr;
    logic [15:0] lfsr_nxt;
    logic        tready_q;
    logic [7:0]  len_q;
    logic        len_vld;
    logic [7:0]  cur_len;
    logic [7:0]  eff_len;
    logic [7:0]  exp_cnt;
    logic [15:0] exp_pkt;
    logic [7:0]  beat_idx;
    logic        accept;
    logic [7:0]  rx_cnt;
    logic [15:0] rx_pkt;
    logic        marker_err;
    logic        keep_err;
    logic        data_mis;
    logic        len_mis;
    logic [3:0]  err_bits;

    assign axis_rx.tready = tready_q;

    assign accept  = axis_rx.tvalid & tready_q & ~clear;
    assign cur_len = (packet_length == 8'd0) ? 8'd4 : packet_length;
    // Until the first post-reset cycle latches it, L follows the input.
    assign eff_len = len_vld ? len_q : cur_len;

    assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

    assign rx_cnt = axis_rx.tdata[55:48];
    assign rx_pkt = axis_rx.tdata[47:32];

    assign marker_err = axis_rx.tdata[31:0] != 32'hFFFF_FFFF;
    assign keep_err   = axis_rx.tkeep != {64{1'b1}};

    always_comb begin
        data_mis = 1'b0;
        for (int i = 1; i < 16; i++) begin
            if (axis_rx.tdata[32*i +: 32] != {8'(i * 17), exp_cnt, exp_pkt})
                data_mis = 1'b1;
        end
    end

    always_comb begin
        len_mis = 1'b0;
        if (axis_rx.tlast)
            len_mis = beat_idx != eff_len;
        else
            len_mis = beat_idx == eff_len;
    end

    always_comb begin
        err_bits = {keep_err, 1'b0, 1'b0, marker_err};
        if (state_q == CHECK) begin
            err_bits[1] = data_mis;
            err_bits[2] = len_mis;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear)
            state_d = SYNC;
        else if (accept)
            state_d = CHECK;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state_q <= SYNC;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr             <= LFSR_SEED;
            tready_q         <= 1'b0;
            len_q            <= 8'd0;
            len_vld          <= 1'b0;
            exp_cnt          <= 8'd0;
            exp_pkt          <= 16'd0;
            beat_idx         <= 8'd1;
            packets_rcvd     <= 64'd0;
            beats_rcvd       <= 64'd0;
            error_count      <= '0;
            error_flags      <= 4'd0;
            first_err_packet <= 16'd0;
            first_err_flags  <= 4'd0;
            synced           <= 1'b0;
        end else if (clear) begin
            lfsr             <= LFSR_SEED;
            tready_q         <= 1'b0;
            len_q            <= cur_len;
            len_vld          <= 1'b1;
            exp_cnt          <= 8'd0;
            exp_pkt          <= 16'd0;
            beat_idx         <= 8'd1;
            packets_rcvd     <= 64'd0;
            beats_rcvd       <= 64'd0;
            error_count      <= '0;
            error_flags      <= 4'd0;
            first_err_packet <= 16'd0;
            first_err_flags  <= 4'd0;
            synced           <= 1'b0;
        end else begin
            lfsr     <= lfsr_nxt;
            tready_q <= throttle_en ? lfsr[0] : 1'b1;
            if (!len_vld) begin
                len_q   <= cur_len;
                len_vld <= 1'b1;
            end
            if (accept) begin
                exp_cnt    <= rx_cnt + 8'd1;
                exp_pkt    <= rx_pkt + {15'd0, axis_rx.tlast};
                beats_rcvd <= beats_rcvd + 64'd1;
                synced     <= 1'b1;
                if (axis_rx.tlast) begin
                    packets_rcvd <= packets_rcvd + 64'd1;
                    len_q        <= cur_len;
                    beat_idx     <= 8'd1;
                end else if (state_q == SYNC) begin
                    beat_idx <= 8'd2;
                end else if (beat_idx != 8'hFF) begin
                    beat_idx <= beat_idx + 8'd1;
                end
                if (|err_bits) begin
                    if (error_count != {ERR_W{1'b1}})
                        error_count <= error_count + 1'b1;
                    error_flags <= error_flags | err_bits;
                    if (error_count == '0) begin
                        first_err_packet <= exp_pkt;
                        first_err_flags  <= err_bits;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_data_checker.sv
// Directed bench for data_checker: clean, throttled, corrupted, short
// packet, marker/keep and clear-during-beat streams.
module tb_data_checker;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        clear = 1'b0;
    logic [7:0]  packet_length = 8'd4;
    logic        throttle_en = 1'b0;
    logic [63:0] packets_rcvd;
    logic [63:0] beats_rcvd;
    logic [31:0] error_count;
    logic [3:0]  error_flags;
    logic [15:0] first_err_packet;
    logic [3:0]  first_err_flags;
    logic        synced;

    axis_rx_if axis_rx();

    data_checker #(
        .LFSR_SEED(16'hACE1),
        .ERR_W(32)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .clear(clear),
        .packet_length(packet_length),
        .throttle_en(throttle_en),
        .axis_rx(axis_rx),
        .packets_rcvd(packets_rcvd),
        .beats_rcvd(beats_rcvd),
        .error_count(error_count),
        .error_flags(error_flags),
        .first_err_packet(first_err_packet),
        .first_err_flags(first_err_flags),
        .synced(synced)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          rdy_hi = 0;
    int          rdy_lo = 0;
    logic [7:0]  cnt = 8'd0;
    logic [15:0] pkt = 16'd0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] make_beat(input logic [7:0] c,
                                               input logic [15:0] p,
                                               input logic [31:0] w0);
        logic [511:0] d;
        for (int i = 0; i < 16; i++)
            d[32*i +: 32] = (i == 0) ? w0 : {8'(i * 17), c, p};
        return d;
    endfunction

    task automatic do_reset(input logic thr);
        resetn = 1'b0;
        throttle_en = thr;
        axis_rx.tvalid = 1'b0;
        axis_rx.tlast = 1'b0;
        axis_rx.tkeep = '1;
        axis_rx.tdata = '0;
        cnt = 8'd0;
        pkt = 16'd0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic send(input logic last, input int fw = 0,
                        input int fb = 0,
                        input logic [63:0] keep = '1,
                        input logic [31:0] w0 = 32'hFFFF_FFFF);
        logic [511:0] d;
        logic ok;
        int n;
        d = make_beat(cnt, pkt, w0);
        if (fw > 0)
            d[32*fw + fb] = ~d[32*fw + fb];
        axis_rx.tdata = d;
        axis_rx.tkeep = keep;
        axis_rx.tlast = last;
        axis_rx.tvalid = 1'b1;
        ok = 1'b0;
        n = 0;
        while (n < 200) begin
            ok = axis_rx.tready;
            if (ok) rdy_hi++;
            else rdy_lo++;
            @(posedge clk);
            @(negedge clk);
            n++;
            if (ok) break;
        end
        axis_rx.tvalid = 1'b0;
        check("accept", ok, 1'b1);
        cnt = cnt + 8'd1;
        pkt = pkt + {15'd0, last};
    endtask

    task automatic stream(input int npk, input int len);
        for (int p = 0; p < npk; p++)
            for (int b = 0; b < len; b++)
                send(b == len - 1);
    endtask

    initial begin
        axis_rx.tvalid = 1'b0;
        axis_rx.tlast = 1'b0;
        axis_rx.tkeep = '1;
        axis_rx.tdata = '0;
        repeat (2) @(negedge clk);
        check("rst_tready", axis_rx.tready, 1'b0);
        check("rst_beats", beats_rcvd, 64'd0);
        check("rst_pkts", packets_rcvd, 64'd0);
        check("rst_errs", error_count, 32'd0);
        check("rst_flags", error_flags, 4'd0);
        check("rst_fpkt", first_err_packet, 16'd0);
        check("rst_fflags", first_err_flags, 4'd0);
        check("rst_synced", synced, 1'b0);
        resetn = 1'b1;
        @(negedge clk);
        check("rel_tready", axis_rx.tready, 1'b1);

        // Clean stream, no backpressure.
        packet_length = 8'd4;
        do_reset(1'b0);
        stream(3, 4);
        check("clean_beats", beats_rcvd, 64'd12);
        check("clean_pkts", packets_rcvd, 64'd3);
        check("clean_errs", error_count, 32'd0);
        check("clean_flags", error_flags, 4'd0);
        check("clean_synced", synced, 1'b1);

        // Same stream with LFSR backpressure.
        do_reset(1'b1);
        rdy_hi = 0;
        rdy_lo = 0;
        stream(3, 4);
        check("thr_beats", beats_rcvd, 64'd12);
        check("thr_pkts", packets_rcvd, 64'd3);
        check("thr_errs", error_count, 32'd0);
        check("thr_stalled", rdy_lo > 0, 1'b1);
        check("thr_ready_hi", rdy_hi, 12);

        // Word7 bit 20 flipped in beat 6 (packet 1).
        do_reset(1'b0);
        for (int b = 1; b <= 12; b++)
            send(b % 4 == 0, (b == 6) ? 7 : 0, 20);
        check("flip_beats", beats_rcvd, 64'd12);
        check("flip_errs", error_count, 32'd1);
        check("flip_flags", error_flags, 4'b0010);
        check("flip_fpkt", first_err_packet, 16'd1);
        check("flip_fflags", first_err_flags, 4'b0010);

        // L=4 via packet_length=0, second packet ends early on beat 3.
        packet_length = 8'd0;
        do_reset(1'b0);
        stream(1, 4);
        stream(1, 3);
        check("len_errs_a", error_count, 32'd1);
        check("len_flags_a", error_flags, 4'b0100);
        stream(1, 4);
        check("len_errs", error_count, 32'd1);
        check("len_flags", error_flags, 4'b0100);
        check("len_fpkt", first_err_packet, 16'd1);
        check("len_pkts", packets_rcvd, 64'd3);

        // Bad TKEEP and marker on one beat.
        packet_length = 8'd4;
        do_reset(1'b0);
        send(1'b0);
        send(1'b0, 0, 0, 64'h7FFF_FFFF_FFFF_FFFF, 32'h0);
        send(1'b0);
        send(1'b1);
        stream(1, 4);
        check("keep_errs", error_count, 32'd1);
        check("keep_flags", error_flags, 4'b1001);
        check("keep_fflags", first_err_flags, 4'b1001);

        // clear coincident with a valid beat.
        do_reset(1'b0);
        send(1'b0);
        send(1'b0);
        axis_rx.tdata = make_beat(cnt, pkt, 32'hFFFF_FFFF);
        axis_rx.tkeep = '1;
        axis_rx.tlast = 1'b0;
        axis_rx.tvalid = 1'b1;
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        axis_rx.tvalid = 1'b0;
        check("clr_tready", axis_rx.tready, 1'b0);
        check("clr_beats", beats_rcvd, 64'd0);
        check("clr_pkts", packets_rcvd, 64'd0);
        check("clr_synced", synced, 1'b0);
        cnt = cnt + 8'd1;
        send(1'b1);
        stream(1, 4);
        check("clr_after_beats", beats_rcvd, 64'd5);
        check("clr_after_pkts", packets_rcvd, 64'd2);
        check("clr_after_errs", error_count, 32'd0);
        check("clr_after_synced", synced, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
